// File: rtl/conv_mac_pipe.sv
// Pipelined signed multiply-accumulate with packet framing and a valid-qualified result.
// Optional build macro CONV_MAC_SAT_EN: saturating accumulator with a sticky ovf flag.
module conv_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         first,
  input  logic                         last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic signed [ACC_WIDTH-1:0]  dout,
  output logic                         dout_valid,
  output logic                         ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int LS = NUM_STAGE - 1;

  if (NUM_STAGE < 1 || ACC_WIDTH < PW) begin : g_cfg_check
    $error("conv_mac_pipe %0d: illegal parameter set", ID);
  end

  // Returns {saturated, sum}.
`ifdef CONV_MAC_SAT_EN
  function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction
`else
  function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [ACC_WIDTH-1:0] b);
    return {1'b0, a + b};
  endfunction
`endif

  logic signed [din0_WIDTH-1:0] a_p0;
  logic signed [din1_WIDTH-1:0] b_p0;
  logic                         vld_p0, first_p0, last_p0;
  logic signed [PW-1:0]         mul_p0;

  logic signed [PW-1:0]         prod_pipe [NUM_STAGE];
  logic [NUM_STAGE-1:0]         vld_pipe, first_pipe, last_pipe;

  logic signed [ACC_WIDTH-1:0]  acc, prod_ext, acc_next;
  logic [ACC_WIDTH:0]           add_res;
  logic                         sat;

  assign mul_p0 = PW'(a_p0) * PW'(b_p0);

  // Input capture (p0), product register, then pure delay stages.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_p0          <= din0;
      b_p0          <= din1;
      first_p0      <= first;
      last_p0       <= last;
      prod_pipe[0]  <= mul_p0;
      first_pipe[0] <= first_p0;
      last_pipe[0]  <= last_p0;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_pipe[i]  <= prod_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  // Accumulate stage.
  assign prod_ext = ACC_WIDTH'(prod_pipe[LS]);
  assign add_res  = acc_add(acc, prod_ext);
  assign sat      = add_res[ACC_WIDTH];
  assign acc_next = first_pipe[LS] ? prod_ext : add_res[ACC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      vld_pipe   <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (ce) begin
        vld_p0      <= in_valid;
        vld_pipe[0] <= vld_p0;
        for (int i = 1; i < NUM_STAGE; i++) vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[LS]) begin
          acc <= acc_next;
          // A packet start reloads without adding, so it can never saturate.
          ovf <= first_pipe[LS] ? 1'b0 : (ovf | sat);
          if (last_pipe[LS]) begin
            dout       <= acc_next;
            dout_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: scoreboard of expected packet results with due edges.
module tb_conv_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, ce, in_valid, first, last;
  logic signed [7:0]  din0;
  logic signed [15:0] din1;
  logic signed [31:0] dout;
  logic               dout_valid, ovf;
  logic signed [23:0] dout24;
  logic               dv24, ovf24;

  conv_mac_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .first(first), .last(last),
    .din0(din0), .din1(din1), .dout(dout), .dout_valid(dout_valid), .ovf(ovf)
  );

  conv_mac_pipe #(.ACC_WIDTH(24)) dut24 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .first(first), .last(last),
    .din0(din0), .din1(din1), .dout(dout24), .dout_valid(dv24), .ovf(ovf24)
  );

  typedef struct {
    logic signed [31:0] val;
    int                 due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

`ifdef CONV_MAC_SAT_EN
  localparam logic signed [63:0] EXP24     = 64'sd8388607;
  localparam logic               EXP24_OVF = 1'b1;
`else
  localparam logic signed [63:0] EXP24     = -64'sd4194304;
  localparam logic               EXP24_OVF = 1'b0;
`endif

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
    repeat (n) tick();
  endtask

  task automatic beat(input logic signed [7:0] a, input logic signed [15:0] b,
                      input bit f, input bit l, input logic signed [31:0] expv);
    din0 = a; din1 = b; in_valid = 1'b1; first = f; last = l;
    tick();
    if (l) q.push_back('{expv, cyc + 4});
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("dout_valid", {63'd0, dout_valid}, {63'd0, ev});
      chk("ovf", {63'd0, ovf}, 64'sd0);
      if (ev) begin
        chk("dout", dout, q[0].val);
        void'(q.pop_front());
      end
    end
  end

  int e;

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; first = 1'b0; last = 1'b0;
    din0 = '0; din1 = '0;
    repeat (2) tick();
    chk("rst_dout", dout, 64'sd0);
    chk("rst_dout_valid", {63'd0, dout_valid}, 64'sd0);
    chk("rst_ovf", {63'd0, ovf}, 64'sd0);
    chk("rst_dout24", dout24, 64'sd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // single beat packet
    beat(-8'sd3, 16'sd1000, 1, 1, -32'sd3000);
    idle(6);

    // four-beat packet
    beat(8'sd2, 16'sd10, 1, 0, 0);
    beat(-8'sd1, 16'sd7, 0, 0, 0);
    beat(8'sd127, -16'sd32768, 0, 0, 0);
    beat(-8'sd128, -16'sd32768, 0, 1, 32'sd32781);
    idle(8);

    // same packet, ce low for two cycles between beats 2 and 3
    beat(8'sd2, 16'sd10, 1, 0, 0);
    beat(-8'sd1, 16'sd7, 0, 0, 0);
    ce = 1'b0;
    repeat (2) tick();
    ce = 1'b1;
    beat(8'sd127, -16'sd32768, 0, 0, 0);
    beat(-8'sd128, -16'sd32768, 0, 1, 32'sd32781);
    idle(8);

    // reset mid-packet discards in-flight beats
    beat(8'sd2, 16'sd10, 1, 0, 0);
    beat(-8'sd1, 16'sd7, 0, 0, 0);
    beat(8'sd127, -16'sd32768, 0, 0, 0);
    din0 = -8'sd128; din1 = -16'sd32768; in_valid = 1'b1; last = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(6);
    chk("mid_rst_dout", dout, 64'sd0);
    beat(8'sd5, 16'sd5, 1, 1, 32'sd25);
    idle(6);

    // 24-bit accumulator overflow, then ovf clear on a new packet
    beat(-8'sd128, -16'sd32768, 1, 0, 0);
    beat(-8'sd128, -16'sd32768, 0, 0, 0);
    beat(-8'sd128, -16'sd32768, 0, 1, 32'sd12582912);
    e = cyc;
    beat(8'sd1, 16'sd1, 1, 1, 32'sd1);
    idle(3);
    chk("acc24_edge", cyc, e + 4);
    chk("acc24_valid", {63'd0, dv24}, 64'sd1);
    chk("acc24_dout", dout24, EXP24);
    chk("acc24_ovf", {63'd0, ovf24}, {63'd0, EXP24_OVF});
    idle(1);
    chk("acc24_next_valid", {63'd0, dv24}, 64'sd1);
    chk("acc24_next_dout", dout24, 64'sd1);
    chk("acc24_ovf_clear", {63'd0, ovf24}, 64'sd0);
    idle(6);

    // back-to-back single-beat packets
    beat(8'sd1, 16'sd1, 1, 1, 32'sd1);
    beat(8'sd2, 16'sd2, 1, 1, 32'sd4);
    beat(8'sd3, 16'sd3, 1, 1, 32'sd9);
    idle(8);

    chk("scoreboard_drained", q.size(), 64'sd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
